multi_channel_trace_logger: RTL

Single-clock, parametrised successor of the tracer/logger pair. Samples a runtime-selectable number of trace channels and packs the samples into memory words. It detects a trigger and records where it occurred. Words go out through a write port to the trace buffer RAM. Trace mode stops after a programmable post-trigger word count; stream mode runs continuously and flags overflow.

---
 rtl/multi_channel_trace_logger.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multi_channel_trace_logger.sv
// rtl/multi_channel_trace_logger.sv - packs N trace channels into words, captures trigger, writes trace RAM
module multi_channel_trace_logger #(
   parameter int WORD_WIDTH = 32,
   parameter int MAX_TRACES = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                            CLK_I,
   input  logic                            RST_NI,
   input  logic                            CONF_UPDATE_I,
   input  logic                            MODE_I,
   input  logic [$clog2(MAX_TRACES):0]     NTRACE_I,
   input  logic [ADDR_WIDTH-1:0]           DELAY_I,
   input  logic                            TRIG_I,
   input  logic [MAX_TRACES-1:0]           TRACE_I,
   input  logic                            WRITE_ALLOW_I,
   output logic                            WRITE_O,
   output logic [ADDR_WIDTH-1:0]           WRITE_PTR_O,
   output logic [WORD_WIDTH-1:0]           DMEM_O,
   output logic                            TRG_EVENT_O,
   output logic [$clog2(WORD_WIDTH)-1:0]   EVENT_POS_O,
   output logic [ADDR_WIDTH-1:0]           EVENT_ADDR_O,
   output logic                            DONE_O,
   output logic                            OVERFLOW_O
);

   localparam int LMAX = $clog2(MAX_TRACES);
   localparam int NW   = LMAX + 1;
   localparam int PW   = $clog2(WORD_WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DONE} state_t;

   state_t                  state_q, state_d;
   logic                    mode_q;
   logic [NW-1:0]           ntr_q;
   logic [ADDR_WIDTH-1:0]   delay_q;
   logic [PW-1:0]           fill_q;
   logic [WORD_WIDTH-1:0]   asm_q;
   logic [WORD_WIDTH-1:0]   out_q;
   logic                    pending_q;
   logic [ADDR_WIDTH-1:0]   ptr_q;
   logic [ADDR_WIDTH-1:0]   dcnt_q;
   logic                    trg_q;
   logic [PW-1:0]           epos_q;
   logic [ADDR_WIDTH-1:0]   eaddr_q;
   logic                    ovf_q;

   logic [NW-1:0]           ntr_in;
   logic                    sampling;
   logic [MAX_TRACES:0]     one_hot;
   logic [MAX_TRACES:0]     lane_lim;
   logic [MAX_TRACES-1:0]   chan_mask;
   logic [PW-1:0]           bit_off;
   logic [WORD_WIDTH-1:0]   samp_w;
   logic [WORD_WIDTH-1:0]   mask_w;
   logic [WORD_WIDTH-1:0]   asm_d;
   logic [PW:0]             s_cnt;
   logic [PW:0]             last_fill;
   logic                    cmpl;
   logic                    trig_hit;
   logic                    wr;

   // Datapath helpers: channel mask, sample placement, word completion, trigger and write qualifiers
   always_comb begin
      ntr_in    = (NTRACE_I > NW'(LMAX)) ? NW'(LMAX) : NTRACE_I;
      sampling  = ~CONF_UPDATE_I & ((state_q == ST_ARMED) | (state_q == ST_POST));
      one_hot   = (MAX_TRACES+1)'(1) << (32'd1 << ntr_q);
      lane_lim  = one_hot - (MAX_TRACES+1)'(1);
      chan_mask = lane_lim[MAX_TRACES-1:0];
      bit_off   = fill_q << ntr_q;
      samp_w    = WORD_WIDTH'(TRACE_I & chan_mask) << bit_off;
      mask_w    = WORD_WIDTH'(chan_mask) << bit_off;
      asm_d     = (asm_q & ~mask_w) | samp_w;
      s_cnt     = (PW+1)'(WORD_WIDTH) >> ntr_q;
      last_fill = s_cnt - (PW+1)'(1);
      cmpl      = sampling & (fill_q == last_fill[PW-1:0]);
      trig_hit  = sampling & (state_q == ST_ARMED) & TRIG_I & ~trg_q;
      wr        = pending_q & WRITE_ALLOW_I;
   end

   // Capture state register
   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: trigger starts the post-trigger phase in trace mode; the last counted word ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARMED: begin
            if (trig_hit && !mode_q) begin
               state_d = (cmpl && (delay_q == '0)) ? ST_DONE : ST_POST;
            end
         end
         ST_POST: begin
            if (cmpl && (dcnt_q == '0)) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = state_q;
      endcase
      if (CONF_UPDATE_I) begin
         state_d = ST_ARMED;
      end
   end

   // Config latch, word assembly, write handshake, overflow, trigger capture and post-trigger count
   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         mode_q    <= 1'b0;
         ntr_q     <= '0;
         delay_q   <= '0;
         fill_q    <= '0;
         asm_q     <= '0;
         out_q     <= '0;
         pending_q <= 1'b0;
         ptr_q     <= '0;
         dcnt_q    <= '0;
         trg_q     <= 1'b0;
         epos_q    <= '0;
         eaddr_q   <= '0;
         ovf_q     <= 1'b0;
      end else if (CONF_UPDATE_I) begin
         mode_q    <= MODE_I;
         ntr_q     <= ntr_in;
         delay_q   <= DELAY_I;
         fill_q    <= '0;
         asm_q     <= '0;
         pending_q <= 1'b0;
         ptr_q     <= '0;
         dcnt_q    <= '0;
         trg_q     <= 1'b0;
         epos_q    <= '0;
         eaddr_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (wr) begin
            pending_q <= 1'b0;
            ptr_q     <= ptr_q + ADDR_WIDTH'(1);
         end
         if (sampling) begin
            asm_q  <= asm_d;
            fill_q <= cmpl ? '0 : fill_q + PW'(1);
         end
         if (cmpl) begin
            out_q     <= asm_d;
            pending_q <= 1'b1;
            if (pending_q && !WRITE_ALLOW_I) begin
               ovf_q <= 1'b1;
            end
         end
         if (trig_hit) begin
            trg_q   <= 1'b1;
            epos_q  <= bit_off;
            // a word still pending will have been written before the trigger word lands
            eaddr_q <= ptr_q + ADDR_WIDTH'(pending_q);
            if (!mode_q) begin
               dcnt_q <= (cmpl && (delay_q != '0)) ? delay_q - ADDR_WIDTH'(1) : delay_q;
            end
         end else if ((state_q == ST_POST) && cmpl && (dcnt_q != '0)) begin
            dcnt_q <= dcnt_q - ADDR_WIDTH'(1);
         end
      end
   end

   assign WRITE_O      = wr;
   assign WRITE_PTR_O  = ptr_q;
   assign DMEM_O       = out_q;
   assign TRG_EVENT_O  = trg_q;
   assign EVENT_POS_O  = epos_q;
   assign EVENT_ADDR_O = eaddr_q;
   assign DONE_O       = (state_q == ST_DONE) & ~pending_q;
   assign OVERFLOW_O   = ovf_q;

endmodule
